// File: rtl/passcode_entry.sv
// passcode_entry: collects keypad digits, compares six-digit code to the password, drives judge/rd/correct.
// Define PASSCODE_PW_CHANGE_EN to allow a new password to be set right after a correct entry.
module passcode_entry #(
   parameter logic [23:0] PW_INIT = 24'h123456
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        key_valid_i,
   input  logic [3:0]  key_code_i,
   input  logic        locked_i,
   input  logic        set_mode_i,
   output logic [2:0]  digit_count_o,
   output logic [23:0] display_o,
   output logic        judge_o,
   output logic        rd_o,
   output logic        correct_o,
   output logic        unlocked_o
);
   typedef enum logic [1:0] {IDLE, ENTRY, CHECK, RESULT} state_t;
   state_t      state_q;
   logic [2:0]  count_q;
   logic [23:0] display_q;
   logic        judge_q, rd_q, correct_q, unlocked_q;
   logic        digit_d, clear_d, enter_d, full_enter_d, store_d, set_entry;
   logic [23:0] pw;
   assign digit_d      = key_valid_i && !locked_i && key_code_i <= 4'd9;
   assign clear_d      = key_valid_i && !locked_i && key_code_i == 4'hE;
   assign enter_d      = key_valid_i && !locked_i && key_code_i == 4'hF;
   assign full_enter_d = enter_d && state_q == ENTRY && count_q == 3'd6;
   assign store_d      = full_enter_d && set_entry;
`ifdef PASSCODE_PW_CHANGE_EN
   logic [23:0] pw_q;
   logic        set_q;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pw_q  <= PW_INIT;
         set_q <= 1'b0;
      end else begin
         if (store_d) pw_q <= display_q;
         if (state_q == RESULT && digit_d) set_q <= correct_q && set_mode_i;
         else if (store_d || clear_d || (locked_i && state_q != CHECK && state_q != RESULT)) set_q <= 1'b0;
      end
   end
   assign pw        = pw_q;
   assign set_entry = set_q;
`else
   logic unused_set_mode;
   assign unused_set_mode = set_mode_i;
   assign pw        = PW_INIT;
   assign set_entry = 1'b0;
`endif
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         count_q    <= 3'd0;
         display_q  <= 24'h0;
         judge_q    <= 1'b0;
         rd_q       <= 1'b0;
         correct_q  <= 1'b0;
         unlocked_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE, ENTRY: begin
               // a digit in IDLE shifts into an all-zero display, so both states share the path
               if (locked_i || clear_d || store_d) begin
                  state_q   <= IDLE;
                  count_q   <= 3'd0;
                  display_q <= 24'h0;
               end else if (digit_d && count_q != 3'd6) begin
                  state_q   <= ENTRY;
                  count_q   <= count_q + 3'd1;
                  display_q <= {display_q[19:0], key_code_i};
               end else if (full_enter_d) begin
                  state_q <= CHECK;
               end
            end
            CHECK: begin
               correct_q  <= display_q == pw;
               unlocked_q <= display_q == pw;
               judge_q    <= 1'b1;
               rd_q       <= 1'b1;
               state_q    <= RESULT;
            end
            default: begin
               rd_q <= 1'b0;
               if (digit_d || clear_d) begin
                  judge_q    <= 1'b0;
                  correct_q  <= 1'b0;
                  unlocked_q <= 1'b0;
                  state_q    <= digit_d ? ENTRY : IDLE;
                  count_q    <= digit_d ? 3'd1 : 3'd0;
                  display_q  <= digit_d ? {20'h0, key_code_i} : 24'h0;
               end
            end
         endcase
      end
   end
   assign digit_count_o = count_q;
   assign display_o     = display_q;
   assign judge_o       = judge_q;
   assign rd_o          = rd_q;
   assign correct_o     = correct_q;
   assign unlocked_o    = unlocked_q;
endmodule
